// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec -- handshaked ALU execute stage for the multi-cycle RISC-V core.
//
// Decodes the 2-bit ALU op class together with func7/func3 into an internal
// operation, executes it on XLEN-bit operands and returns the result through
// a valid/ready output register. Single-cycle ops take one cycle; the
// optional iterative multiply/divide unit adds XLEN+1 cycles (XLEN radix-2
// steps plus one sign-fixup cycle).
//
// Optional feature macro: ALU_MULDIV_EN
//   defined   -> RV32M/RV64M multiply/divide datapath, counter, BUSY and FIX
//                states are compiled in.
//   undefined -> the func7 0000001 class decodes as illegal (single cycle),
//                busy is always 0 and BUSY/FIX are never entered.
//
// Parameters
//   XLEN  operand/result width (32 or 64)
//   SHW   shift-amount width, derived from XLEN (do not override)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous abort, overrides accept
//   in_valid   in   request valid
//   in_ready   out  request accepted when in_valid & in_ready
//   aluop      in   op class: 00 mem-address, 01 branch, 10 R-type, 11 I-type
//   func7      in   instruction func7 (I-type: only bit 5 matters, shifts)
//   func3      in   instruction func3
//   op_a/op_b  in   operands (I-type: op_b is the sign-extended immediate)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts result
//   result     out  registered result
//   zero       out  result == 0
//   illegal    out  undecodable op, qualifies out_valid
//   busy       out  multi-cycle op in progress
// ---------------------------------------------------------------------------
module alu_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Internal operation codes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_MD   = 4'd10;  // variant carried by func3
    localparam logic [3:0] OP_ILL  = 4'd11;

    // Base func3 table shared by R-type func7=0000000 and I-type
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    logic [1:0]      state_q,   state_d;
    logic [XLEN-1:0] result_q,  result_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      dec_op;
    logic            dec_md;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        dec_op = OP_ADD;
        case (aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                case (func3)
                    3'b000, 3'b001: dec_op = OP_SUB;
                    3'b100, 3'b101: dec_op = OP_SLT;
                    3'b110, 3'b111: dec_op = OP_SLTU;
                    default:        dec_op = OP_ILL;
                endcase
            end
            2'b10: begin
                case (func7)
                    7'b0000000: dec_op = base_op(func3);
                    7'b0100000: begin
                        if (func3 == 3'b000)      dec_op = OP_SUB;
                        else if (func3 == 3'b101) dec_op = OP_SRA;
                        else                      dec_op = OP_ILL;
                    end
`ifdef ALU_MULDIV_EN
                    7'b0000001: dec_op = OP_MD;
`else
                    7'b0000001: dec_op = OP_ILL;
`endif
                    default:    dec_op = OP_ILL;
                endcase
            end
            default: begin
                // I-type: func7 is immediate bits except bit 5 on shifts
                if (func3 == 3'b001 && func7[5])      dec_op = OP_ILL;
                else if (func3 == 3'b101 && func7[5]) dec_op = OP_SRA;
                else                                  dec_op = base_op(func3);
            end
        endcase
    end

    assign dec_md = (dec_op == OP_MD);

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_MD:   alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY) | (state_q == ST_FIX);
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign zero      = (result_q == '0);

`ifdef ALU_MULDIV_EN
    // ------------------------------------------------------------------
    // Iterative multiply/divide unit
    //   multiply: {hi,lo} starts as {0,|b|}, m=|a|; shift-add right.
    //   divide:   {hi,lo} starts as {0,|a|}, m=|b|; restoring shift-subtract,
    //             quotient ends in lo, remainder in hi.
    // Dividing by zero naturally yields quotient all ones and remainder |a|;
    // suppressing the quotient negation in that case gives the required
    // all-ones result for signed div too.
    // ------------------------------------------------------------------
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0]   ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2 = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q,  hi_d;
    logic [XLEN-1:0] lo_q,  lo_d;
    logic [XLEN-1:0] m_q,   m_d;
    logic            neg_q, neg_d;
    logic [2:0]      f3_q,  f3_d;

    logic            sgn_a, sgn_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] md_res;

    // Only mulh, mulhsu, div, rem treat op_a as signed; op_b is signed for
    // mulh, div, rem.
    always_comb begin
        sgn_a = op_a[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b010) |
                                (func3 == 3'b100) | (func3 == 3'b110));
        sgn_b = op_b[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b100) |
                                (func3 == 3'b110));
        mag_a = sgn_a ? (~op_a + ONE) : op_a;
        mag_b = sgn_b ? (~op_b + ONE) : op_b;
    end

    assign mul_sum   = {1'b0, hi_q} + ({1'b0, m_q} & {(XLEN+1){lo_q[0]}});
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, m_q};

    always_comb begin
        prod_fix = neg_q ? (~{hi_q, lo_q} + ONE2) : {hi_q, lo_q};
        case (f3_q)
            3'b000:                 md_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_res = neg_q ? (~lo_q + ONE) : lo_q;
            default:                md_res = neg_q ? (~hi_q + ONE) : hi_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        m_d   = m_q;
        neg_d = neg_q;
        f3_d  = f3_q;
        if (accept && dec_md) begin
            cnt_d = CW'(XLEN);
            f3_d  = func3;
            hi_d  = '0;
            if (!func3[2]) begin
                lo_d  = mag_b;
                m_d   = mag_a;
                neg_d = sgn_a ^ sgn_b;
            end else begin
                lo_d  = mag_a;
                m_d   = mag_b;
                if (func3[1]) neg_d = sgn_a;                            // rem
                else          neg_d = (sgn_a ^ sgn_b) & (op_b != '0);   // div
            end
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - CW'(1);
            if (!f3_q[2]) begin
                hi_d = mul_sum[XLEN:1];
                lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end else if (!div_diff[XLEN]) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end
        if (flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            neg_q <= 1'b0;
            f3_q  <= 3'b000;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            neg_q <= neg_d;
            f3_q  <= f3_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM and output register
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;

        // A new request may be taken in IDLE, or in DONE while the current
        // result is being consumed.
        if (accept) begin
            if (dec_md) begin
                state_d   = ST_BUSY;
                illegal_d = 1'b0;
            end else begin
                state_d   = ST_DONE;
                result_d  = alu_res;
                illegal_d = (dec_op == OP_ILL);
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
`ifdef ALU_MULDIV_EN
                ST_BUSY: begin
                    if (cnt_q == CW'(1)) state_d = ST_FIX;
                end
                ST_FIX: begin
                    state_d  = ST_DONE;
                    result_d = md_res;
                end
`endif
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec -- directed self-checking bench for alu_exec (XLEN=32).
// Inputs are driven and outputs sampled on the falling clock edge.
// Multiply/divide expectations are selected by ALU_MULDIV_EN.
// ---------------------------------------------------------------------------
module tb_alu_exec;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      aluop;
    logic [6:0]      func7;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_exec #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .func7     (func7),
        .func3     (func3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        aluop    = op;
        func7    = f7;
        func3    = f3;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
    endtask

    // One full transaction with out_ready held high; called on a falling edge.
    task automatic run(input string tag, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        drive(op, f7, f3, a, b);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 200);
        $display("txn %-10s a=0x%08h b=0x%08h -> result=0x%08h zero=%0d illegal=%0d latency=%0d",
                 tag, a, b, result, zero, illegal, lat);
        chk({tag, ".result"},  result,  exp_res);
        chk({tag, ".zero"},    zero,    exp_res == 32'h0);
        chk({tag, ".illegal"}, illegal, exp_ill);
        chk({tag, ".latency"}, lat,     exp_lat);
        @(negedge clk);
        chk({tag, ".drain"},   out_valid, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop     = 2'b00;
        func7     = 7'h00;
        func3     = 3'b000;
        op_a      = '0;
        op_b      = '0;

        repeat (3) @(negedge clk);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.result",    result,    32'h0);
        chk("rst.zero",      zero,      1'b1);
        chk("rst.illegal",   illegal,   1'b0);
        chk("rst.busy",      busy,      1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready",  in_ready,  1'b1);

        // Single-cycle operations
        run("add",    2'b10, 7'h00, 3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 1);
        run("beq",    2'b01, 7'h00, 3'b000, 32'h1234,     32'h1234,     32'h0,        1'b0, 1);
        run("srai",   2'b11, 7'h20, 3'b101, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
        run("srli",   2'b11, 7'h00, 3'b101, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
        run("sub",    2'b10, 7'h20, 3'b000, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1);
        run("slt",    2'b10, 7'h00, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
        run("sltu",   2'b10, 7'h00, 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        run("sll",    2'b10, 7'h00, 3'b001, 32'd1,        32'h0000003F, 32'h80000000, 1'b0, 1);
        run("sra",    2'b10, 7'h20, 3'b101, 32'h80000010, 32'd4,        32'hF8000001, 1'b0, 1);
        run("xor",    2'b10, 7'h00, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);
        run("or",     2'b10, 7'h00, 3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1);
        run("and",    2'b10, 7'h00, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
        run("memadd", 2'b00, 7'h55, 3'b010, 32'h00001000, 32'hFFFFFFFC, 32'h00000FFC, 1'b0, 1);
        run("blt",    2'b01, 7'h00, 3'b100, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0, 1);
        run("bltu",   2'b01, 7'h00, 3'b110, 32'hFFFFFFFE, 32'd1,        32'd0,        1'b0, 1);
        run("slli",   2'b11, 7'h00, 3'b001, 32'd3,        32'd2,        32'd12,       1'b0, 1);
        run("addi",   2'b11, 7'h7F, 3'b000, 32'd10,       32'hFFFFFFFF, 32'd9,        1'b0, 1);

        // Undecodable ops
        run("ill.br",   2'b01, 7'h00, 3'b011, 32'd9, 32'd3, 32'h0, 1'b1, 1);
        run("ill.r20",  2'b10, 7'h20, 3'b100, 32'd9, 32'd3, 32'h0, 1'b1, 1);
        run("ill.r40",  2'b10, 7'h40, 3'b000, 32'd9, 32'd3, 32'h0, 1'b1, 1);
        run("ill.slli", 2'b11, 7'h20, 3'b001, 32'd9, 32'd3, 32'h0, 1'b1, 1);

        // Flush in the accept cycle drops the request
        out_ready = 1'b1;
        drive(2'b10, 7'h00, 3'b000, 32'd1, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flushdrop.out_valid", out_valid, 1'b0);
        chk("flushdrop.in_ready",  in_ready,  1'b1);
        @(negedge clk);
        chk("flushdrop.late",      out_valid, 1'b0);
        $display("txn flushdrop  request dropped by flush");

        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        drive(2'b10, 7'h00, 3'b000, 32'd1, 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.out_valid", out_valid, 1'b1);
        chk("bp.result",    result,    32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.hold_in_ready",  in_ready,  1'b0);
            chk("bp.hold_out_valid", out_valid, 1'b1);
            chk("bp.hold_result",    result,    32'd3);
            chk("bp.hold_zero",      zero,      1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.released", out_valid, 1'b0);
        $display("txn backpress  result=0x%08h held 3 cycles then consumed", result);

        // Back-to-back single-cycle ops at one per cycle
        drive(2'b10, 7'h00, 3'b000, 32'd10, 32'd1);
        @(negedge clk);
        chk("b2b.first_valid",    out_valid, 1'b1);
        chk("b2b.first_result",   result,    32'd11);
        chk("b2b.first_in_ready", in_ready,  1'b1);
        drive(2'b10, 7'h20, 3'b000, 32'd10, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.second_valid",  out_valid, 1'b1);
        chk("b2b.second_result", result,    32'd9);
        @(negedge clk);
        chk("b2b.drain", out_valid, 1'b0);
        $display("txn back2back  results 11 then 9 on consecutive cycles");

`ifdef ALU_MULDIV_EN
        run("mul",    2'b10, 7'h01, 3'b000, 32'd6,        32'd7,        32'd42,       1'b0, XLEN + 2);
        run("mulneg", 2'b10, 7'h01, 3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, XLEN + 2);
        run("mulh",   2'b10, 7'h01, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, XLEN + 2);
        run("mulhsu", 2'b10, 7'h01, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, XLEN + 2);
        run("mulhu",  2'b10, 7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, XLEN + 2);
        run("div0",   2'b10, 7'h01, 3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, XLEN + 2);
        run("rem0",   2'b10, 7'h01, 3'b110, 32'd7,        32'd0,        32'd7,        1'b0, XLEN + 2);
        run("divu0",  2'b10, 7'h01, 3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, XLEN + 2);
        run("divovf", 2'b10, 7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, XLEN + 2);
        run("removf", 2'b10, 7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, XLEN + 2);
        run("divneg", 2'b10, 7'h01, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, XLEN + 2);
        run("remneg", 2'b10, 7'h01, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, XLEN + 2);
        run("divu",   2'b10, 7'h01, 3'b101, 32'd100,      32'd7,        32'd14,       1'b0, XLEN + 2);
        run("remu",   2'b10, 7'h01, 3'b111, 32'd100,      32'd7,        32'd2,        1'b0, XLEN + 2);

        // Flush while BUSY: operation abandoned, no result
        drive(2'b10, 7'h01, 3'b101, 32'd100, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mdflush.busy_before", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("mdflush.busy",      busy,      1'b0);
        chk("mdflush.out_valid", out_valid, 1'b0);
        chk("mdflush.in_ready",  in_ready,  1'b1);
        cnt = 0;
        for (int i = 0; i < XLEN + 8; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("mdflush.no_result", cnt, 0);
        $display("txn mdflush    divide abandoned by flush");

        // Reset while BUSY: outputs return to reset values at once
        drive(2'b10, 7'h01, 3'b100, 32'd100, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mdrst.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mdrst.out_valid", out_valid, 1'b0);
        chk("mdrst.busy",      busy,      1'b0);
        chk("mdrst.result",    result,    32'h0);
        chk("mdrst.zero",      zero,      1'b1);
        chk("mdrst.illegal",   illegal,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mdrst.in_ready", in_ready, 1'b1);
        $display("txn mdreset    divide abandoned by reset");
        run("postrst", 2'b10, 7'h00, 3'b000, 32'd20, 32'd22, 32'd42, 1'b0, 1);
`else
        run("mul.ill",  2'b10, 7'h01, 3'b000, 32'd6,   32'd7, 32'h0, 1'b1, 1);
        run("divu.ill", 2'b10, 7'h01, 3'b101, 32'd100, 32'd7, 32'h0, 1'b1, 1);
        chk("nomd.busy", busy, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
